// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit-index counter width; a 1-bit counter is kept even for WIDTH=1.
  function automatic int calc_cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa_slice.sv
// Combinational full-adder slice: two half-adder cells whose carries are ORed.
module fa_slice (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;
  logic g1;
  logic g2;

  // First half adder combines the operand bits, second folds in the carry.
  assign p    = a ^ b;
  assign g1   = a & b;
  assign s    = p ^ cin;
  assign g2   = p & cin;
  assign cout = g1 | g2;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one shared full-adder slice, LSB-first, one bit per cycle.
// Optional subtract mode (in_sub port) is built when SERIAL_ADDER_SUB_EN is defined.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int CNT_W = calc_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t            state_reg,    state_next;
  logic [WIDTH-1:0]  a_sh_reg,     a_sh_next;
  logic [WIDTH-1:0]  b_sh_reg,     b_sh_next;
  logic [WIDTH-1:0]  sum_sh_reg,   sum_sh_next;
  logic [WIDTH-1:0]  out_sum_reg,  out_sum_next;
  logic              out_cout_reg, out_cout_next;
  logic              carry_reg,    carry_next;
  logic [CNT_W-1:0]  cnt_reg,      cnt_next;
  logic              sub_reg,      sub_next;

  logic              fa_b;
  logic              fa_s;
  logic              fa_cout;
  logic              accept_sub;
  logic [WIDTH-1:0]  sum_shifted;

`ifdef SERIAL_ADDER_SUB_EN
  assign accept_sub = in_sub;
`else
  assign accept_sub = 1'b0;
`endif

  // Subtraction is A + ~B + 1: invert B at the slice input, seed carry with 1.
  assign fa_b = b_sh_reg[0] ^ sub_reg;

  fa_slice u_fa_slice (
    .a    (a_sh_reg[0]),
    .b    (fa_b),
    .cin  (carry_reg),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // New sum bit enters at the MSB; the shift-based form stays legal for WIDTH=1.
  assign sum_shifted = (sum_sh_reg >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  always_comb begin
    state_next    = state_reg;
    a_sh_next     = a_sh_reg;
    b_sh_next     = b_sh_reg;
    sum_sh_next   = sum_sh_reg;
    out_sum_next  = out_sum_reg;
    out_cout_next = out_cout_reg;
    carry_next    = carry_reg;
    cnt_next      = cnt_reg;
    sub_next      = sub_reg;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    busy          = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_sh_next  = in_a;
          b_sh_next  = in_b;
          sub_next   = accept_sub;
          carry_next = accept_sub;
          cnt_next   = '0;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        busy        = 1'b1;
        a_sh_next   = a_sh_reg >> 1;
        b_sh_next   = b_sh_reg >> 1;
        sum_sh_next = sum_shifted;
        carry_next  = fa_cout;
        if (cnt_reg == LAST_BIT) begin
          // Result registers are separate so out_sum holds while the next op shifts.
          out_sum_next  = sum_shifted;
          out_cout_next = fa_cout;
          cnt_next      = '0;
          state_next    = ST_DONE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      a_sh_reg     <= '0;
      b_sh_reg     <= '0;
      sum_sh_reg   <= '0;
      out_sum_reg  <= '0;
      out_cout_reg <= 1'b0;
      carry_reg    <= 1'b0;
      cnt_reg      <= '0;
      sub_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      a_sh_reg     <= a_sh_next;
      b_sh_reg     <= b_sh_next;
      sum_sh_reg   <= sum_sh_next;
      out_sum_reg  <= out_sum_next;
      out_cout_reg <= out_cout_next;
      carry_reg    <= carry_next;
      cnt_reg      <= cnt_next;
      sub_reg      <= sub_next;
    end
  end

  assign out_sum  = out_sum_reg;
  assign out_cout = out_cout_reg;

endmodule
